// File: rtl/cache_wb_dm_if.sv
`default_nettype none
// ============================================================================
// Module  : cache_wb_dm_if
// Brief   : Core-side and memory-side signal bundle for cache_wb_dm.
// Revision: 1.0 - initial release
// ============================================================================
interface cache_wb_dm_if #(
    parameter int ARCH_BITS       = 32,
    parameter int CACHE_LINE_SIZE = 128
);
    logic                       cpu_req;
    logic                       cpu_we;
    logic [ARCH_BITS-1:0]       cpu_addr;
    logic [ARCH_BITS-1:0]       cpu_wdata;
    logic [ARCH_BITS-1:0]       cpu_rdata;
    logic                       cpu_ready;
    logic                       mem_req;
    logic                       mem_we;
    logic [ARCH_BITS-1:0]       mem_addr;
    logic [CACHE_LINE_SIZE-1:0] mem_wdata;
    logic [CACHE_LINE_SIZE-1:0] mem_rdata;
    logic                       mem_ack;

    // The cache serves the core and drives the memory port.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    // Environment view: core plus line-wide memory.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/cache_wb_dm.sv
`default_nettype none
// ============================================================================
// Module  : cache_wb_dm
// Brief   : Direct-mapped write-back write-allocate data cache, stalls on miss.
// Revision: 1.0 - initial release
// ============================================================================
module cache_wb_dm #(
    parameter int ARCH_BITS       = 32,
    parameter int CACHE_LINES     = 4,
    parameter int CACHE_LINE_SIZE = 128
) (
    input  wire logic        clk,
    input  wire logic        rst,
    cache_wb_dm_if.slave     bus
);
    localparam int OFFSET_B  = $clog2(ARCH_BITS / 8);
    localparam int OFFSET_W  = $clog2(CACHE_LINE_SIZE / ARCH_BITS);
    localparam int LINE_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS  = ARCH_BITS - OFFSET_B - OFFSET_W - LINE_BITS;
    localparam int IDX_LSB   = OFFSET_B + OFFSET_W;
    localparam int TAG_LSB   = IDX_LSB + LINE_BITS;

    localparam logic [IDX_LSB-1:0] c_offZero = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WB     = 2'd1,
        ST_REFILL = 2'd2
    } state_t;

    state_t                     r_state;
    logic [CACHE_LINES-1:0]     r_valid;
    logic [CACHE_LINES-1:0]     r_dirty;
    logic [TAG_BITS-1:0]        r_tag  [CACHE_LINES];
    logic [CACHE_LINE_SIZE-1:0] r_data [CACHE_LINES];
    logic                       r_memReq;
    logic                       r_memWe;
    logic [ARCH_BITS-1:0]       r_memAddr;
    logic [CACHE_LINE_SIZE-1:0] r_memWdata;

    logic [TAG_BITS-1:0]        w_reqTag;
    logic [LINE_BITS-1:0]       w_idx;
    logic [OFFSET_W-1:0]        w_wordOff;
    logic                       w_hit;
    logic                       w_ready;

    assign w_reqTag  = bus.cpu_addr[ARCH_BITS-1:TAG_LSB];
    assign w_idx     = bus.cpu_addr[TAG_LSB-1:IDX_LSB];
    assign w_wordOff = bus.cpu_addr[IDX_LSB-1:OFFSET_B];
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_reqTag);
    assign w_ready   = !rst && (r_state == ST_IDLE) && bus.cpu_req && w_hit;

    assign bus.cpu_ready = w_ready;
    assign bus.cpu_rdata = r_data[w_idx][w_wordOff*ARCH_BITS +: ARCH_BITS];
    assign bus.mem_req   = r_memReq;
    assign bus.mem_we    = r_memWe;
    assign bus.mem_addr  = r_memAddr;
    assign bus.mem_wdata = r_memWdata;

    // Miss handling relies on the core holding its request stable, so the
    // live cpu_addr still names the index and tag throughout WB/REFILL.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_valid  <= '0;
            r_dirty  <= '0;
            r_memReq <= 1'b0;
            r_memWe  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cpu_req) begin
                        if (w_hit) begin
                            if (bus.cpu_we) begin
                                r_dirty[w_idx] <= 1'b1;
                            end
                        end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            r_state    <= ST_WB;
                            r_memReq   <= 1'b1;
                            r_memWe    <= 1'b1;
                            r_memAddr  <= {r_tag[w_idx], w_idx, c_offZero};
                            r_memWdata <= r_data[w_idx];
                        end else begin
                            r_state   <= ST_REFILL;
                            r_memReq  <= 1'b1;
                            r_memWe   <= 1'b0;
                            r_memAddr <= {w_reqTag, w_idx, c_offZero};
                        end
                    end
                end
                ST_WB: begin
                    if (bus.mem_ack) begin
                        r_state   <= ST_REFILL;
                        r_memWe   <= 1'b0;
                        r_memAddr <= {w_reqTag, w_idx, c_offZero};
                    end
                end
                ST_REFILL: begin
                    if (bus.mem_ack) begin
                        r_state        <= ST_IDLE;
                        r_memReq       <= 1'b0;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_memReq <= 1'b0;
                    r_memWe  <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data storage carry no reset; valid bits guard their contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if ((r_state == ST_REFILL) && bus.mem_ack) begin
                r_data[w_idx] <= bus.mem_rdata;
                r_tag[w_idx]  <= w_reqTag;
            end else if (w_ready && bus.cpu_we) begin
                r_data[w_idx][w_wordOff*ARCH_BITS +: ARCH_BITS] <= bus.cpu_wdata;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cache_wb_dm.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_wb_dm
// Brief   : Directed vector bench for cache_wb_dm with an acking memory model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cache_wb_dm;
    localparam int ACK_LAT = 3;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] expRdata;
        logic        chkData;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_wb_dm_if #(.ARCH_BITS(32), .CACHE_LINE_SIZE(128)) bus();

    logic         modelAck    = 1'b0;
    logic         spuriousAck = 1'b0;
    logic [127:0] modelRdata  = '0;
    assign bus.mem_ack   = modelAck | spuriousAck;
    assign bus.mem_rdata = modelRdata;

    cache_wb_dm #(
        .ARCH_BITS(32),
        .CACHE_LINES(4),
        .CACHE_LINE_SIZE(128)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    logic [127:0] memLines [256];
    int           waitCnt     = 0;
    int           wbCount     = 0;
    int           refillCount = 0;
    int           stableErrs  = 0;
    logic [31:0]  lastWbAddr     = '0;
    logic [31:0]  lastRefillAddr = '0;
    logic [127:0] lastWbData     = '0;
    logic         firstWe;
    logic [31:0]  firstAddr;
    logic [127:0] firstWdata;

    vec_t vecs [10];

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hA000_0000 | (a & 32'hFFFF_FFFC);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: acks ACK_LAT cycles after a request appears, 1-cycle pulse.
    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [31:0] b;
            b = 32'(i) << 4;
            memLines[i] = {pat(b + 32'd12), pat(b + 32'd8), pat(b + 32'd4), pat(b)};
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                modelAck = 1'b0;
                waitCnt  = 0;
            end else if (modelAck) begin
                modelAck = 1'b0;
                waitCnt  = 0;
            end else if (bus.mem_req) begin
                waitCnt++;
                if (waitCnt == 1) begin
                    firstWe    = bus.mem_we;
                    firstAddr  = bus.mem_addr;
                    firstWdata = bus.mem_wdata;
                end else if (bus.mem_we !== firstWe || bus.mem_addr !== firstAddr ||
                             (firstWe && bus.mem_wdata !== firstWdata)) begin
                    stableErrs++;
                end
                if (waitCnt == ACK_LAT) begin
                    modelAck = 1'b1;
                    if (bus.mem_we) begin
                        memLines[bus.mem_addr[11:4]] = bus.mem_wdata;
                        wbCount++;
                        lastWbAddr = bus.mem_addr;
                        lastWbData = bus.mem_wdata;
                    end else begin
                        modelRdata = memLines[bus.mem_addr[11:4]];
                        refillCount++;
                        lastRefillAddr = bus.mem_addr;
                    end
                end
            end
        end
    end

    // Holds the request until cpu_ready, returning stall cycles before completion.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int cycles);
        logic done;
        done   = 1'b0;
        cycles = 0;
        rdata  = '0;
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (bus.cpu_ready) begin
                rdata = bus.cpu_rdata;
                done  = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL access timeout: addr %h got no cpu_ready, required within 40 cycles", addr);
        end
        @(posedge clk);
    endtask

    task automatic goIdle();
        @(negedge clk);
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
    endtask

    task automatic applyVecs(input int lo, input int hi);
        logic [31:0] rd;
        int          cyc;
        for (int i = lo; i <= hi; i++) begin
            spuriousAck = vecs[i].ack;
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, cyc);
            check($sformatf("vec%0d latency", i), 128'(cyc), 128'(0));
            if (vecs[i].chkData) begin
                check($sformatf("vec%0d rdata", i), 128'(rd), 128'(vecs[i].expRdata));
            end
        end
        spuriousAck = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          cyc;
        logic        seen;

        vecs[0] = '{1'b0, 32'h0000_004C, 32'h0,         1'b0, pat(32'h4C),  1'b1};
        vecs[1] = '{1'b1, 32'h0000_0044, 32'hDEADBEEF,  1'b0, 32'h0,        1'b0};
        vecs[2] = '{1'b0, 32'h0000_0044, 32'h0,         1'b0, 32'hDEADBEEF, 1'b1};
        vecs[3] = '{1'b0, 32'h0000_0040, 32'h0,         1'b0, pat(32'h40),  1'b1};
        vecs[4] = '{1'b0, 32'h0000_0048, 32'h0,         1'b1, pat(32'h48),  1'b1};
        vecs[5] = '{1'b0, 32'h0000_0C14, 32'h0,         1'b0, pat(32'hC14), 1'b1};
        vecs[6] = '{1'b0, 32'h0000_002C, 32'h0,         1'b1, pat(32'h2C),  1'b1};
        vecs[7] = '{1'b1, 32'h0000_0038, 32'hCAFEF00D,  1'b1, 32'h0,        1'b0};
        vecs[8] = '{1'b0, 32'h0000_0038, 32'h0,         1'b0, 32'hCAFEF00D, 1'b1};
        vecs[9] = '{1'b0, 32'h0000_0044, 32'h0,         1'b1, 32'hDEADBEEF, 1'b1};

        // Reset with a request pending: nothing may respond.
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'h40;
        bus.cpu_wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst cpu_ready", 128'(bus.cpu_ready), 128'(0));
        check("rst mem_req",   128'(bus.mem_req),   128'(0));
        check("rst mem_we",    128'(bus.mem_we),    128'(0));
        @(negedge clk);
        rst = 1'b0;
        bus.cpu_req = 1'b0;

        // Cold load: clean refill, ready one cycle after the ack.
        access(1'b0, 32'h40, 32'h0, rd, cyc);
        check("t1 latency",     128'(cyc),            128'(ACK_LAT + 1));
        check("t1 rdata",       128'(rd),             128'(pat(32'h40)));
        check("t1 refill addr", 128'(lastRefillAddr), 128'(32'h40));
        check("t1 wb count",    128'(wbCount),        128'(0));

        // Hits and a store hit on the filled line.
        applyVecs(0, 3);
        goIdle();
        check("t2 refill count", 128'(refillCount), 128'(1));
        check("t2 wb count",     128'(wbCount),     128'(0));

        // Conflict with the dirty line: writeback then refill.
        access(1'b0, 32'h440, 32'h0, rd, cyc);
        check("t3 latency",      128'(cyc),              128'(2 * (ACK_LAT + 1)));
        check("t3 rdata",        128'(rd),               128'(pat(32'h440)));
        check("t3 wb count",     128'(wbCount),          128'(1));
        check("t3 wb addr",      128'(lastWbAddr),       128'(32'h40));
        check("t3 wb word1",     128'(lastWbData[63:32]), 128'(32'hDEADBEEF));
        check("t3 wb word0",     128'(lastWbData[31:0]),  128'(pat(32'h40)));
        check("t3 refill addr",  128'(lastRefillAddr),   128'(32'h440));
        // Victim left clean: reloading the old line needs no writeback.
        access(1'b0, 32'h44, 32'h0, rd, cyc);
        check("t3 reload latency", 128'(cyc),     128'(ACK_LAT + 1));
        check("t3 reload rdata",   128'(rd),      128'(32'hDEADBEEF));
        check("t3 reload wb",      128'(wbCount), 128'(1));

        // Store miss to an empty index: refill only, then the store lands.
        access(1'b1, 32'h810, 32'h12345678, rd, cyc);
        check("t4 latency",      128'(cyc),         128'(ACK_LAT + 1));
        check("t4 wb count",     128'(wbCount),     128'(1));
        check("t4 refill count", 128'(refillCount), 128'(4));
        access(1'b0, 32'h810, 32'h0, rd, cyc);
        check("t4 hit latency",  128'(cyc), 128'(0));
        check("t4 hit rdata",    128'(rd),  128'(32'h12345678));
        access(1'b0, 32'hC10, 32'h0, rd, cyc);
        check("t4 evict latency", 128'(cyc),              128'(2 * (ACK_LAT + 1)));
        check("t4 evict wb addr", 128'(lastWbAddr),       128'(32'h810));
        check("t4 evict wb data", 128'(lastWbData[31:0]), 128'(32'h12345678));
        check("t4 evict rdata",   128'(rd),               128'(pat(32'hC10)));

        // Spurious ack while idle must not start anything.
        goIdle();
        spuriousAck = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("t6 idle mem_req",   128'(bus.mem_req),   128'(0));
        check("t6 idle cpu_ready", 128'(bus.cpu_ready), 128'(0));
        spuriousAck = 1'b0;
        access(1'b0, 32'h20, 32'h0, rd, cyc);
        check("t6 fill2 latency", 128'(cyc), 128'(ACK_LAT + 1));
        access(1'b0, 32'h30, 32'h0, rd, cyc);
        check("t6 fill3 latency", 128'(cyc), 128'(ACK_LAT + 1));
        applyVecs(4, 9);
        goIdle();
        check("t6 wb count",     128'(wbCount),     128'(2));
        check("t6 refill count", 128'(refillCount), 128'(7));

        // Reset during a refill aborts it and invalidates every line.
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h100;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            #1;
            if (bus.mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        check("t5 refill started", 128'(seen), 128'(1));
        rst = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        #1;
        check("t5 rst mem_req",   128'(bus.mem_req),   128'(0));
        check("t5 rst cpu_ready", 128'(bus.cpu_ready), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        access(1'b0, 32'h48, 32'h0, rd, cyc);
        check("t5 miss latency", 128'(cyc), 128'(ACK_LAT + 1));
        check("t5 rdata",        128'(rd),  128'(pat(32'h48)));
        goIdle();

        check("mem side stable", 128'(stableErrs), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
